// File: rtl/ifetch_ctrl.sv
// ----------------------------------------------------------------------------
// ifetch_ctrl
//
// Instruction-fetch sequencer. Owns the PC, drives a combinational,
// word-addressed instruction memory, captures every returned word together
// with its PC into a small FIFO and presents the FIFO head to decode under a
// valid/ready handshake. Handles redirects (branch/jump), halt and
// misaligned / out-of-window fetch faults.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous, active-low reset
//   imem_addr      out  byte address to instruction memory (the PC register)
//   imem_rdata     in   instruction word for imem_addr, same cycle
//   out_valid      out  FIFO head holds a valid instruction
//   out_pc         out  PC of the FIFO head (holds last value when empty)
//   out_instr      out  instruction of the FIFO head (holds last value when empty)
//   out_ready      in   decode accepts the head this cycle
//   redirect_valid in   flush the FIFO and restart fetch at redirect_pc
//   redirect_pc    in   new fetch address
//   halt           in   suspend fetching; the FIFO keeps draining
//   fetch_fault    out  sticky fault flag, cleared only by redirect or reset
//   state          out  FSM state for debug: 0 FETCH, 1 HOLD, 2 FAULT
// ----------------------------------------------------------------------------
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          ADRBITS  = 10,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        out_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        fetch_fault,
    output logic [1:0]  state
);

    localparam int          PW           = $clog2(DEPTH);
    localparam int          CW           = PW + 1;
    localparam logic [31:0] WINDOW_BYTES = 32'd4 << ADRBITS;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [31:0]   pc_q,        pc_d;
    state_t        state_q,     state_d;
    logic          fault_q,     fault_d;
    logic [CW-1:0] count_q,     count_d;
    logic [PW-1:0] wr_ptr_q,    wr_ptr_d;
    logic [PW-1:0] rd_ptr_q,    rd_ptr_d;
    logic [31:0]   out_pc_q,    out_pc_d;
    logic [31:0]   out_instr_q, out_instr_d;

    // FIFO storage; contents are meaningless outside [rd_ptr, rd_ptr+count)
    // so no reset is needed here.
    logic [31:0]   fifo_pc_q    [DEPTH];
    logic [31:0]   fifo_instr_q [DEPTH];

    // ------------------------------------------------------------------
    // Fetch / handshake decode
    // ------------------------------------------------------------------
    logic [31:0]   pc_offset;
    logic          inr;
    logic          pop;
    logic          push;
    logic [CW-1:0] count_after_pop;

    always_comb begin
        // Unsigned offset from the window base: a PC below the base wraps to
        // a huge value, so a single compare covers both window edges.
        pc_offset = pc_q - RESET_PC;
        inr       = (pc_q[1:0] == 2'b00) && (pc_offset < WINDOW_BYTES);

        // A pop that coincides with a redirect is discarded with the flush.
        pop  = (count_q != '0) && out_ready && !redirect_valid;

        // When full, a same-cycle pop frees the slot the push needs.
        push = (state_q == ST_FETCH) && inr && !redirect_valid &&
               ((count_q < CW'(DEPTH)) || pop);

        count_after_pop = count_q - CW'(pop);
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        pc_d     = pc_q;
        state_d  = state_q;
        fault_d  = fault_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (redirect_valid) begin
            // Redirect overrides everything, including a pending fault.
            pc_d     = redirect_pc;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fault_d  = 1'b0;
            state_d  = halt ? ST_HOLD : ST_FETCH;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                pc_d     = pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);

            case (state_q)
                ST_FETCH: begin
                    // halt takes precedence over a fault; the fault is
                    // re-detected once fetching resumes.
                    if (halt) begin
                        state_d = ST_HOLD;
                    end else if (!inr) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!halt) begin
                        state_d = ST_FETCH;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output head registers
    // ------------------------------------------------------------------
    // The head is registered so the outputs can hold their last value when
    // the FIFO empties. If the FIFO is empty after this cycle's pop and a
    // word is being pushed, that word becomes the head on this edge; it is
    // taken straight from the fetch path because it is not in storage yet.
    always_comb begin
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;
        if (count_d != '0) begin
            if (push && (count_after_pop == '0)) begin
                out_pc_d    = pc_q;
                out_instr_d = imem_rdata;
            end else begin
                out_pc_d    = fifo_pc_q[rd_ptr_d];
                out_instr_d = fifo_instr_q[rd_ptr_d];
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q        <= RESET_PC;
            state_q     <= ST_FETCH;
            fault_q     <= 1'b0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_pc_q    <= '0;
            out_instr_q <= '0;
        end else begin
            pc_q        <= pc_d;
            state_q     <= state_d;
            fault_q     <= fault_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]    <= pc_q;
            fifo_instr_q[wr_ptr_q] <= imem_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem_addr   = pc_q;
    assign out_valid   = (count_q != '0);
    assign out_pc      = out_pc_q;
    assign out_instr   = out_instr_q;
    assign fetch_fault = fault_q;
    assign state       = state_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ifetch_ctrl
//
// Table-driven bench for ifetch_ctrl. Each table row holds one input pattern,
// the number of cycles to apply it and the hand-derived state, fault flag and
// PC expected after the row. A reference model runs alongside: every fetched
// word is pushed onto a scoreboard queue and popped/compared when decode
// accepts the DUT's head. Reset corner cases are hand-written sequences.
// ----------------------------------------------------------------------------
module tb_ifetch_ctrl;

    localparam logic [31:0] BASE = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        fetch_fault;
    logic [1:0]  state;

    always #5 clk = ~clk;

    ifetch_ctrl #(
        .RESET_PC (BASE),
        .ADRBITS  (10),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_ready      (out_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .fetch_fault    (fetch_fault),
        .state          (state)
    );

    // Memory image: word k of the window holds 0x1000_0000 + k.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'h1000_0000 + ((a - BASE) >> 2);
    endfunction

    assign imem_rdata = word_at(imem_addr);

    // ------------------------------------------------------------------
    // Checking infrastructure
    // ------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        exp_q[$];
    logic [31:0] m_pc;
    logic [1:0]  m_st;
    logic        m_fault;

    task automatic model_reset();
        exp_q.delete();
        m_pc    = BASE;
        m_st    = 2'd0;
        m_fault = 1'b0;
    endtask

    // Called at a falling edge: apply inputs, check the DUT against the
    // model, advance the model across the next rising edge, wait for the
    // following falling edge.
    task automatic do_cycle(input logic rdy, input logic hlt, input logic rv,
                            input logic [31:0] rpc);
        logic inr;
        logic pop;
        logic push;
        int   sz;

        out_ready      = rdy;
        halt           = hlt;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;

        chk("out_valid",   32'(out_valid),   32'(exp_q.size() != 0));
        chk("imem_addr",   imem_addr,        m_pc);
        chk("state",       32'(state),       32'(m_st));
        chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
        if (exp_q.size() != 0) begin
            chk("out_pc",    out_pc,    exp_q[0].pc);
            chk("out_instr", out_instr, exp_q[0].instr);
            if (rdy && !rv) begin
                $display("t=%0t accept pc=%h instr=%h", $time, out_pc, out_instr);
            end
        end

        inr = (m_pc[1:0] == 2'b00) && ((m_pc - BASE) < 32'd4096);
        sz  = exp_q.size();
        pop = rdy && (sz > 0) && !rv;
        if (rv) begin
            exp_q.delete();
            m_pc    = rpc;
            m_fault = 1'b0;
            m_st    = hlt ? 2'd1 : 2'd0;
        end else begin
            push = (m_st == 2'd0) && inr && ((sz < 2) || pop);
            if (pop) begin
                void'(exp_q.pop_front());
            end
            if (push) begin
                exp_q.push_back('{m_pc, word_at(m_pc)});
                m_pc = m_pc + 32'd4;
            end
            case (m_st)
                2'd0: begin
                    if (hlt) begin
                        m_st = 2'd1;
                    end else if (!inr) begin
                        m_st    = 2'd2;
                        m_fault = 1'b1;
                    end
                end
                2'd1: if (!hlt) m_st = 2'd0;
                default: ;
            endcase
        end
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        int          cycles;
        logic        ready;
        logic        hlt;
        logic        rv;
        logic [31:0] rpc;
        logic [1:0]  exp_state;
        logic        exp_fault;
        logic [31:0] exp_pc;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs[NVEC];

    initial begin
        // cycles rdy halt rv  rpc           state fault pc-after
        vecs[0]  = '{5, 1'b0, 1'b0, 1'b0, 32'h0,     2'd0, 1'b0, 32'h0000_3008}; // stall: FIFO fills
        vecs[1]  = '{6, 1'b1, 1'b0, 1'b0, 32'h0,     2'd0, 1'b0, 32'h0000_3020}; // full + pop + push
        vecs[2]  = '{1, 1'b1, 1'b0, 1'b1, 32'h3100,  2'd0, 1'b0, 32'h0000_3100}; // redirect over pop
        vecs[3]  = '{4, 1'b1, 1'b0, 1'b0, 32'h0,     2'd0, 1'b0, 32'h0000_3110};
        vecs[4]  = '{3, 1'b1, 1'b1, 1'b0, 32'h0,     2'd1, 1'b0, 32'h0000_3114}; // halt
        vecs[5]  = '{3, 1'b1, 1'b0, 1'b0, 32'h0,     2'd0, 1'b0, 32'h0000_311C}; // resume
        vecs[6]  = '{1, 1'b1, 1'b0, 1'b1, 32'h3FF0,  2'd0, 1'b0, 32'h0000_3FF0};
        vecs[7]  = '{6, 1'b1, 1'b0, 1'b0, 32'h0,     2'd2, 1'b1, 32'h0000_4000}; // run off window
        vecs[8]  = '{1, 1'b1, 1'b1, 1'b1, 32'h3000,  2'd1, 1'b0, 32'h0000_3000}; // redirect + halt
        vecs[9]  = '{2, 1'b1, 1'b0, 1'b0, 32'h0,     2'd0, 1'b0, 32'h0000_3004};
        vecs[10] = '{1, 1'b1, 1'b0, 1'b1, 32'h3002,  2'd0, 1'b0, 32'h0000_3002}; // misaligned
        vecs[11] = '{2, 1'b1, 1'b0, 1'b0, 32'h0,     2'd2, 1'b1, 32'h0000_3002};
        vecs[12] = '{1, 1'b1, 1'b0, 1'b1, 32'h2FFC,  2'd0, 1'b0, 32'h0000_2FFC}; // below base
        vecs[13] = '{1, 1'b1, 1'b1, 1'b0, 32'h0,     2'd1, 1'b0, 32'h0000_2FFC}; // halt beats fault
        vecs[14] = '{2, 1'b1, 1'b0, 1'b0, 32'h0,     2'd2, 1'b1, 32'h0000_2FFC};
        vecs[15] = '{1, 1'b1, 1'b0, 1'b1, 32'h3000,  2'd0, 1'b0, 32'h0000_3000};
        vecs[16] = '{3, 1'b1, 1'b0, 1'b0, 32'h0,     2'd0, 1'b0, 32'h0000_300C};
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        reset          = 1'b1;
        out_ready      = 1'b0;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        #1 reset = 1'b0;
        model_reset();

        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset out_valid",   32'(out_valid),   32'd0);
        chk("reset out_pc",      out_pc,           32'd0);
        chk("reset out_instr",   out_instr,        32'd0);
        chk("reset state",       32'(state),       32'd0);
        chk("reset fetch_fault", 32'(fetch_fault), 32'd0);
        chk("reset imem_addr",   imem_addr,        BASE);

        @(negedge clk);
        reset = 1'b1;

        for (int v = 0; v < NVEC; v++) begin
            for (int c = 0; c < vecs[v].cycles; c++) begin
                do_cycle(vecs[v].ready, vecs[v].hlt, vecs[v].rv, vecs[v].rpc);
            end
            #1;
            chk($sformatf("vec%0d state", v),     32'(state),       32'(vecs[v].exp_state));
            chk($sformatf("vec%0d fault", v),     32'(fetch_fault), 32'(vecs[v].exp_fault));
            chk($sformatf("vec%0d imem_addr", v), imem_addr,        vecs[v].exp_pc);
            $display("t=%0t vector %0d done state=%0d fault=%0d pc=%h",
                     $time, v, state, fetch_fault, imem_addr);
        end

        // Fill the FIFO right at the window top so it is full and faulted,
        // then assert reset while a redirect is pending.
        do_cycle(1'b0, 1'b0, 1'b1, 32'h3FF8);
        do_cycle(1'b0, 1'b0, 1'b0, 32'h0);
        do_cycle(1'b0, 1'b0, 1'b0, 32'h0);
        do_cycle(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("pre-reset out_valid", 32'(out_valid),   32'd1);
        chk("pre-reset fault",     32'(fetch_fault), 32'd1);
        chk("pre-reset out_pc",    out_pc,           32'h0000_3FF8);

        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3200;
        #1 reset = 1'b0;
        #1;
        chk("async reset out_valid",   32'(out_valid),   32'd0);
        chk("async reset fetch_fault", 32'(fetch_fault), 32'd0);
        chk("async reset state",       32'(state),       32'd0);
        chk("async reset imem_addr",   imem_addr,        BASE);
        chk("async reset out_pc",      out_pc,           32'd0);
        $display("t=%0t async reset applied", $time);
        model_reset();

        @(negedge clk);
        redirect_valid = 1'b0;
        reset          = 1'b1;
        for (int c = 0; c < 5; c++) begin
            do_cycle(1'b1, 1'b0, 1'b0, 32'h0);
        end
        #1;
        chk("restart imem_addr", imem_addr, 32'h0000_3014);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    // Safety net against a stuck run.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
